ysyx_210247_exe_muldiv: RTL and testbench

- Iterative RV64M multiply/divide unit inside the EXE stage.
- Consumes operands and an M-op code decoded from the ID→EXE pipeline register payload. Returns a 64-bit result to the EXE result mux.
- EXE holds its allow-in low while this unit is busy. A pipeline flush kills any in-flight operation.

---
 rtl/ysyx_210247_exe_muldiv_pkg.sv | 32 +++
 rtl/ysyx_210247_div_iter.sv | 54 +++++
 rtl/ysyx_210247_exe_muldiv.sv | 170 +++++++++++++++++
 tb/tb_ysyx_210247_exe_muldiv.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ysyx_210247_exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage RV64M multiply/divide unit.
//   XLEN            operand / result width (64 only)
//   W_ITER, D_ITER  iteration counts for word and doubleword ops
//   F3_*            funct3 encodings of the M-extension ops, OP_WORD_BIT marks *W
//   state_t         IDLE / CALC / DONE states of the control FSM
package ysyx_210247_exe_muldiv_pkg;

  localparam int XLEN   = 64;
  localparam int W_ITER = 32;
  localparam int D_ITER = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam int         OP_WORD_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_210247_div_iter.sv
// Restoring divider datapath: one shift-subtract step per enabled cycle.
//   clk, rst       clock, asynchronous active-low reset
//   load           capture dividend/divisor magnitudes (word selects 32-bit mode)
//   step           perform one restoring step
//   quo_next/rem_next  quotient/remainder as they will be after the current step;
//                  the top samples these on the final step so the result is
//                  ready in the same edge that enters DONE.
module ysyx_210247_div_iter
  import ysyx_210247_exe_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [XLEN:0]   shifted;
  logic            ge;

  // Dividend bits leave from the top of quo_reg while quotient bits enter at
  // the bottom; word ops preload the dividend in the upper half so that after
  // 32 steps quo_reg holds the zero-extended 32-bit quotient.
  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    ge       = (shifted >= {1'b0, dvs_reg});
    // When ge, the true difference is below the divisor, so 64-bit wrap is exact.
    rem_next = ge ? (shifted[XLEN-1:0] - dvs_reg) : shifted[XLEN-1:0];
    quo_next = {quo_reg[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
    end else if (load) begin
      quo_reg <= word ? {dividend[31:0], 32'b0} : dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
    end else if (step) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
    end
  end

endmodule

// File: rtl/ysyx_210247_exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
//   clk, rst        clock, asynchronous active-low reset
//   flush           kills any in-flight op, returns to IDLE
//   req_valid/req_ready, req_op, src1, src2   request (req_op[3] = word op)
//   resp_valid/resp_ready, resp_data          result, held until consumed
module ysyx_210247_exe_muldiv
  import ysyx_210247_exe_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  input  logic            resp_ready
);

  state_t            state_reg, state_next;
  logic [6:0]        cnt_reg;
  logic              word_reg;
  logic [2:0]        f3_reg;
  logic              neg_q_reg, neg_r_reg;
  logic [2*XLEN-1:0] mcand_reg, acc_reg, acc_next, prod;
  logic [XLEN-1:0]   mplier_reg;
  logic              resp_valid_reg;
  logic [XLEN-1:0]   resp_data_reg;

  logic [2:0]        f3;
  logic              word, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, spec_res;
  logic              div_zero, div_ovf, special, accept, last_step;
  logic [XLEN-1:0]   quo_next, rem_next, q_fix, r_fix, div_sel, final_res;

  // Request decode and operand preparation
  always_comb begin
    f3       = req_op[2:0];
    word     = req_op[OP_WORD_BIT];
    is_div   = f3[2];
    is_rem   = f3[2] & f3[1];
    // Word multiplies (including the never-issued 001-011 codes) act as MULW,
    // whose low half does not depend on signedness.
    a_signed = is_div ? !f3[0] : (!word && (f3 == F3_MULH || f3 == F3_MULHSU));
    b_signed = is_div ? !f3[0] : (!word && f3 == F3_MULH);
    if (word && is_div && f3[0]) begin
      a_ext = {32'b0, src1[31:0]};
      b_ext = {32'b0, src2[31:0]};
    end else if (word) begin
      a_ext = sext32(src1[31:0]);
      b_ext = sext32(src2[31:0]);
    end else begin
      a_ext = src1;
      b_ext = src2;
    end
    a_neg = a_signed & a_ext[XLEN-1];
    b_neg = b_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    div_zero = is_div && (word ? (src2[31:0] == 32'b0) : (src2 == '0));
    div_ovf  = is_div && !f3[0] &&
               (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                     : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
    special  = div_zero | div_ovf;
    if (div_zero)
      spec_res = is_rem ? (word ? sext32(src1[31:0]) : src1) : '1;
    else
      spec_res = is_rem ? '0 : (word ? sext32(src1[31:0]) : src1);

    accept    = (state_reg == ST_IDLE) && req_valid && !flush;
    last_step = (state_reg == ST_CALC) && (cnt_reg == 7'd1);
  end

  // Result fix-up, computed from the values the final step produces
  always_comb begin
    acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    prod      = neg_q_reg ? -acc_next : acc_next;
    q_fix     = neg_q_reg ? -quo_next : quo_next;
    r_fix     = neg_r_reg ? -rem_next : rem_next;
    div_sel   = f3_reg[1] ? r_fix : q_fix;
    final_res = '0;
    if (f3_reg[2])
      final_res = word_reg ? sext32(div_sel[31:0]) : div_sel;
    else if (word_reg)
      final_res = sext32(prod[31:0]);
    else if (f3_reg == F3_MUL)
      final_res = prod[XLEN-1:0];
    else
      final_res = prod[2*XLEN-1:XLEN];
  end

  ysyx_210247_div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state_reg == ST_CALC),
    .word     (word),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Control FSM
  always_comb begin
    state_next = state_reg;
    req_ready  = (state_reg == ST_IDLE);
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_reg == 7'd1) state_next = ST_DONE;
      ST_DONE: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Datapath and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      word_reg       <= 1'b0;
      f3_reg         <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else if (flush) begin
      resp_valid_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= word ? 7'(W_ITER) : 7'(D_ITER);
      word_reg   <= word;
      f3_reg     <= f3;
      neg_q_reg  <= a_neg ^ b_neg;
      neg_r_reg  <= a_neg;
      mcand_reg  <= {{XLEN{1'b0}}, a_mag};
      mplier_reg <= b_mag;
      acc_reg    <= '0;
      if (special) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= spec_res;
      end
    end else if (state_reg == ST_CALC) begin
      cnt_reg    <= cnt_reg - 7'd1;
      acc_reg    <= acc_next;
      mcand_reg  <= {mcand_reg[2*XLEN-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
      if (last_step) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= final_res;
      end
    end else if (state_reg == ST_DONE && resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_ysyx_210247_exe_muldiv.sv
// Directed testbench for ysyx_210247_exe_muldiv.
module tb_ysyx_210247_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'h0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_ready = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  ysyx_210247_exe_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .src1       (src1),
    .src2       (src2),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the response, check latency/data, optionally
  // stall resp_ready for 'hold' cycles, then consume.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input int hold);
    int n;
    logic [63:0] held;
    check({tag, ".req_ready"}, {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
    tick();
    // Garbage on the request while busy must be ignored.
    req_op = 4'h0; src1 = 64'hDEAD_BEEF_0BAD_F00D; src2 = 64'h1234;
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    check({tag, ".latency"}, 64'(n + 1), 64'(lat));
    check({tag, ".data"}, resp_data, exp);
    $display("%s op=%h src1=%h src2=%h -> %h (exp %h) lat=%0d", tag, op, a, b,
             resp_data, exp, n + 1);
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, {63'b0, resp_valid}, 64'd1);
      check({tag, ".hold_data"}, resp_data, held);
      check({tag, ".hold_ready"}, {63'b0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".post_valid"}, {63'b0, resp_valid}, 64'd0);
    check({tag, ".post_ready"}, {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    // Reset state
    #2;
    check("rst.valid", {63'b0, resp_valid}, 64'd0);
    check("rst.data", resp_data, 64'd0);
    check("rst.ready", {63'b0, req_ready}, 64'd1);
    tick();
    rst = 1'b1;
    tick();

    do_op("MUL",    4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op("MULH",   4'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 65, 0);
    do_op("MULHU",  4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    do_op("MULHSU", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("MULW",   4'h8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("DIV",    4'h4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op("REM",    4'h6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("DIVUW",  4'hD, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0);
    do_op("REMU",   4'h7, 64'd100, 64'd7, 64'd2, 65, 0);
    do_op("DIVU0",  4'h5, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("DIVOVF", 4'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 0);
    do_op("REMW0",  4'hE, 64'h0000_0001_2345_6789, 64'd0, 64'h0000_0000_2345_6789, 1, 0);
    do_op("HOLD",   4'h4, 64'd100, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFEC, 65, 10);

    // Flush at CALC cycle 20
    req_valid = 1'b1; req_op = 4'h0; src1 = 64'd11; src2 = 64'd13;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("FLUSH.ready", {63'b0, req_ready}, 64'd1);
    check("FLUSH.valid", {63'b0, resp_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("FLUSH.no_resp", 64'(seen), 64'd0);
    $display("FLUSH killed MUL 11x13 at CALC cycle 20, spurious responses=%0d", seen);
    do_op("MUL3x5", 4'h0, 64'd3, 64'd5, 64'd15, 65, 0);

    // Asynchronous reset mid-CALC
    req_valid = 1'b1; req_op = 4'h4; src1 = 64'd1000; src2 = 64'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("ARST.valid", {63'b0, resp_valid}, 64'd0);
    check("ARST.data", resp_data, 64'd0);
    check("ARST.ready", {63'b0, req_ready}, 64'd1);
    #2 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("ARST.no_resp", 64'(seen), 64'd0);
    $display("ARST pulsed mid-DIV, spurious responses=%0d", seen);
    do_op("DIVW",   4'hC, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 33, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
